// File: rtl/idu_issue_ctrl.sv
// Decode-stage issue controller: one-entry decode slot, load-use scoreboard,
// valid/ready issue to EXU and redirect flush.
module idu_issue_ctrl #(
   parameter int CPU_WIDTH      = 32,
   parameter int REG_ADDR_WIDTH = 5,
   parameter int CNT_WIDTH      = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      enable,
   input  logic                      ifu_valid,
   input  logic [CPU_WIDTH-1:0]      ifu_pc,
   input  logic [CPU_WIDTH-1:0]      ifu_inst,
   output logic                      ifu_ready,
   output logic                      id_valid,
   output logic [CPU_WIDTH-1:0]      id_pc,
   output logic [CPU_WIDTH-1:0]      id_inst,
   input  logic                      dec_reg_wen,
   input  logic [REG_ADDR_WIDTH-1:0] dec_reg_waddr,
   input  logic [REG_ADDR_WIDTH-1:0] dec_reg1_raddr,
   input  logic [REG_ADDR_WIDTH-1:0] dec_reg2_raddr,
   input  logic                      dec_mem_ren,
   input  logic                      exu_ready,
   output logic                      issue,
   output logic                      hazard_stall,
   input  logic                      exu_branch_en,
   input  logic                      exu_jump_en,
   input  logic                      wb_valid,
   input  logic [REG_ADDR_WIDTH-1:0] wb_addr,
   output logic [CNT_WIDTH-1:0]      stall_cnt
);

   localparam int SB_DEPTH = 2 ** REG_ADDR_WIDTH;
   localparam logic [CPU_WIDTH-1:0] NOP_INST = CPU_WIDTH'(32'h0000_0013);

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } slot_state_t;

   slot_state_t         state_q, state_d;
   logic [SB_DEPTH-1:0] sb_q, sb_d;
   logic                flush;
   logic                rs1_busy, rs2_busy;
   logic                hazard;
   logic                load_slot;
   logic                sb_set;

   assign id_valid = (state_q == FULL);
   assign flush    = exu_branch_en | exu_jump_en;
   assign rs1_busy = sb_q[dec_reg1_raddr] & (dec_reg1_raddr != '0);
   assign rs2_busy = sb_q[dec_reg2_raddr] & (dec_reg2_raddr != '0);

   // Outputs are forced low while rst_n is asserted so EXU/IFU never see a stale slot.
   assign hazard       = rst_n & id_valid & (rs1_busy | rs2_busy);
   assign hazard_stall = hazard & enable;
   assign issue        = rst_n & enable & id_valid & exu_ready & ~hazard & ~flush;
   assign ifu_ready    = rst_n & enable & ~flush & (~id_valid | issue);
   assign load_slot    = ifu_valid & ifu_ready;
   assign sb_set       = issue & dec_mem_ren & dec_reg_wen & (dec_reg_waddr != '0);

   always_comb begin
      state_d = state_q;
      if (enable) begin
         case (state_q)
            EMPTY: begin
               if (!flush && load_slot) state_d = FULL;
            end
            FULL: begin
               if (flush)          state_d = EMPTY;
               else if (load_slot) state_d = FULL;
               else if (issue)     state_d = EMPTY;
            end
            default: state_d = EMPTY;
         endcase
      end
   end

   // Writeback clears run even when disabled; a same-cycle set overrides the clear.
   always_comb begin
      sb_d = sb_q;
      if (wb_valid && (wb_addr != '0)) sb_d[wb_addr] = 1'b0;
      if (sb_set)                      sb_d[dec_reg_waddr] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= EMPTY;
         id_pc     <= '0;
         id_inst   <= NOP_INST;
         sb_q      <= '0;
         stall_cnt <= '0;
      end else begin
         state_q <= state_d;
         sb_q    <= sb_d;
         if (load_slot) begin
            id_pc   <= ifu_pc;
            id_inst <= ifu_inst;
         end
         if (hazard_stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_WIDTH'(1);
      end
   end

endmodule

// File: tb/tb_idu_issue_ctrl.sv
// Directed bench for idu_issue_ctrl; the bench plays the decoder by driving dec_* for
// whatever instruction it expects to be sitting in the slot.
module tb_idu_issue_ctrl;

   logic        clk = 1'b0;
   logic        rst_n, enable, ifu_valid;
   logic [31:0] ifu_pc, ifu_inst;
   logic        ifu_ready, id_valid;
   logic [31:0] id_pc, id_inst;
   logic        dec_reg_wen, dec_mem_ren;
   logic [4:0]  dec_reg_waddr, dec_reg1_raddr, dec_reg2_raddr;
   logic        exu_ready, issue, hazard_stall, exu_branch_en, exu_jump_en;
   logic        wb_valid;
   logic [4:0]  wb_addr;
   logic [15:0] stall_cnt;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   idu_issue_ctrl #(.CPU_WIDTH(32), .REG_ADDR_WIDTH(5), .CNT_WIDTH(16)) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable),
      .ifu_valid(ifu_valid), .ifu_pc(ifu_pc), .ifu_inst(ifu_inst), .ifu_ready(ifu_ready),
      .id_valid(id_valid), .id_pc(id_pc), .id_inst(id_inst),
      .dec_reg_wen(dec_reg_wen), .dec_reg_waddr(dec_reg_waddr),
      .dec_reg1_raddr(dec_reg1_raddr), .dec_reg2_raddr(dec_reg2_raddr),
      .dec_mem_ren(dec_mem_ren), .exu_ready(exu_ready), .issue(issue),
      .hazard_stall(hazard_stall), .exu_branch_en(exu_branch_en), .exu_jump_en(exu_jump_en),
      .wb_valid(wb_valid), .wb_addr(wb_addr), .stall_cnt(stall_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic dec(input logic wen, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic ren);
      dec_reg_wen    = wen;
      dec_reg_waddr  = rd;
      dec_reg1_raddr = rs1;
      dec_reg2_raddr = rs2;
      dec_mem_ren    = ren;
   endtask

   initial begin
      rst_n = 1'b0; enable = 1'b1; ifu_valid = 1'b1; ifu_pc = 32'h44; ifu_inst = 32'h0010_0093;
      exu_ready = 1'b1; exu_branch_en = 1'b0; exu_jump_en = 1'b0;
      wb_valid = 1'b0; wb_addr = '0;
      dec(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
      repeat (2) tick;
      #1;
      chk("rst_id_valid", 32'(id_valid), 32'd0);
      chk("rst_id_pc", id_pc, 32'd0);
      chk("rst_id_inst", id_inst, 32'h13);
      chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
      chk("rst_ifu_ready", 32'(ifu_ready), 32'd0);
      chk("rst_issue", 32'(issue), 32'd0);

      // Stream of four ADDIs, one per cycle
      rst_n = 1'b1; ifu_pc = 32'h0; ifu_inst = 32'h0010_0093;
      #1;
      chk("c0_ifu_ready", 32'(ifu_ready), 32'd1);
      chk("c0_issue", 32'(issue), 32'd0);
      tick;
      dec(1'b1, 5'd1, 5'd0, 5'd0, 1'b0);
      ifu_pc = 32'h4;
      #1;
      chk("c1_id_valid", 32'(id_valid), 32'd1);
      chk("c1_id_pc", id_pc, 32'h0);
      chk("c1_issue", 32'(issue), 32'd1);
      chk("c1_ifu_ready", 32'(ifu_ready), 32'd1);
      for (int k = 2; k <= 4; k++) begin
         tick;
         if (k < 4) ifu_pc = 32'(4 * k);
         else       ifu_valid = 1'b0;
         #1;
         chk("stream_id_pc", id_pc, 32'(4 * (k - 1)));
         chk("stream_issue", 32'(issue), 32'd1);
      end
      tick;
      #1;
      chk("stream_empty", 32'(id_valid), 32'd0);
      chk("stream_no_issue", 32'(issue), 32'd0);

      // LW x5 followed by ADD x6,x5,x1: load-use stall until writeback
      ifu_valid = 1'b1; ifu_pc = 32'h10; ifu_inst = 32'h0001_2283;
      tick;
      dec(1'b1, 5'd5, 5'd2, 5'd0, 1'b1);
      ifu_pc = 32'h14; ifu_inst = 32'h0012_8333;
      #1;
      chk("lw5_id_pc", id_pc, 32'h10);
      chk("lw5_issue", 32'(issue), 32'd1);
      chk("lw5_no_stall", 32'(hazard_stall), 32'd0);
      tick;
      dec(1'b1, 5'd6, 5'd5, 5'd1, 1'b0);
      ifu_pc = 32'h18; ifu_inst = 32'h0001_2003;
      #1;
      chk("use5_stall1", 32'(hazard_stall), 32'd1);
      chk("use5_no_issue", 32'(issue), 32'd0);
      chk("use5_ifu_ready", 32'(ifu_ready), 32'd0);
      tick;
      #1;
      chk("use5_stall2", 32'(hazard_stall), 32'd1);
      chk("use5_pc_held", id_pc, 32'h14);
      tick;
      wb_valid = 1'b1; wb_addr = 5'd5;
      #1;
      chk("use5_stall3", 32'(hazard_stall), 32'd1);
      tick;
      wb_valid = 1'b0;
      #1;
      chk("use5_released", 32'(hazard_stall), 32'd0);
      chk("use5_issue", 32'(issue), 32'd1);
      chk("use5_stall_cnt", 32'(stall_cnt), 32'd3);
      chk("use5_accept_next", 32'(ifu_ready), 32'd1);

      // LW x0 then consumer of x0: never a stall
      tick;
      dec(1'b1, 5'd0, 5'd2, 5'd0, 1'b1);
      ifu_pc = 32'h1C; ifu_inst = 32'h0000_0433;
      #1;
      chk("lw0_pc", id_pc, 32'h18);
      chk("lw0_issue", 32'(issue), 32'd1);
      tick;
      dec(1'b1, 5'd8, 5'd0, 5'd0, 1'b0);
      ifu_pc = 32'h20; ifu_inst = 32'h0001_2483;
      #1;
      chk("use0_no_stall", 32'(hazard_stall), 32'd0);
      chk("use0_issue", 32'(issue), 32'd1);

      // LW x9 issues, then a jump flushes the next slot while IFU offers an instruction
      tick;
      dec(1'b1, 5'd9, 5'd2, 5'd0, 1'b1);
      ifu_pc = 32'h24; ifu_inst = 32'h0020_85b3;
      #1;
      chk("lw9_issue", 32'(issue), 32'd1);
      tick;
      dec(1'b1, 5'd11, 5'd1, 5'd2, 1'b0);
      exu_jump_en = 1'b1; ifu_pc = 32'h28; ifu_inst = 32'h0000_0013;
      #1;
      chk("jmp_issue", 32'(issue), 32'd0);
      chk("jmp_ifu_ready", 32'(ifu_ready), 32'd0);
      tick;
      exu_jump_en = 1'b0; ifu_valid = 1'b0;
      #1;
      chk("jmp_flushed", 32'(id_valid), 32'd0);
      chk("jmp_pc_kept", id_pc, 32'h24);
      ifu_valid = 1'b1; ifu_pc = 32'h40; ifu_inst = 32'h0004_8633;
      #1;
      chk("jmp_refill_ready", 32'(ifu_ready), 32'd1);
      tick;
      dec(1'b1, 5'd12, 5'd9, 5'd0, 1'b0);
      ifu_valid = 1'b0; wb_valid = 1'b1; wb_addr = 5'd9;
      #1;
      chk("use9_after_flush_stall", 32'(hazard_stall), 32'd1);
      chk("use9_pc", id_pc, 32'h40);
      tick;
      wb_valid = 1'b0;
      ifu_valid = 1'b1; ifu_pc = 32'h44; ifu_inst = 32'h0001_2383;
      #1;
      chk("use9_issue", 32'(issue), 32'd1);
      chk("use9_stall_cnt", 32'(stall_cnt), 32'd4);

      // LW x7 issue with same-cycle writeback of x7: set wins
      tick;
      dec(1'b1, 5'd7, 5'd2, 5'd0, 1'b1);
      wb_valid = 1'b1; wb_addr = 5'd7;
      ifu_pc = 32'h48; ifu_inst = 32'h0013_86b3;
      #1;
      chk("lw7_issue", 32'(issue), 32'd1);
      tick;
      wb_valid = 1'b0; ifu_valid = 1'b0;
      dec(1'b1, 5'd13, 5'd7, 5'd1, 1'b0);
      #1;
      chk("setwins_stall", 32'(hazard_stall), 32'd1);
      chk("setwins_no_issue", 32'(issue), 32'd0);

      // Three disabled cycles: frozen slot/counter, writeback clear still lands
      tick;
      enable = 1'b0; wb_valid = 1'b1; wb_addr = 5'd7; ifu_valid = 1'b1; ifu_pc = 32'h4C;
      #1;
      chk("dis_issue", 32'(issue), 32'd0);
      chk("dis_ifu_ready", 32'(ifu_ready), 32'd0);
      chk("dis_hazard_stall", 32'(hazard_stall), 32'd0);
      chk("dis_stall_cnt", 32'(stall_cnt), 32'd5);
      for (int k = 0; k < 2; k++) begin
         tick;
         wb_valid = 1'b0;
         #1;
         chk("dis_hold_issue", 32'(issue), 32'd0);
         chk("dis_hold_pc", id_pc, 32'h48);
         chk("dis_hold_valid", 32'(id_valid), 32'd1);
         chk("dis_hold_cnt", 32'(stall_cnt), 32'd5);
      end
      tick;
      enable = 1'b1;
      ifu_valid = 1'b1; ifu_pc = 32'h50; ifu_inst = 32'h0001_2503;
      #1;
      chk("en_sb_cleared", 32'(hazard_stall), 32'd0);
      chk("en_issue", 32'(issue), 32'd1);
      chk("en_cnt", 32'(stall_cnt), 32'd5);
      chk("en_pc", id_pc, 32'h48);

      // LW x10 then a long stall to saturate the counter, then reset mid-stall
      tick;
      dec(1'b1, 5'd10, 5'd2, 5'd0, 1'b1);
      ifu_pc = 32'h54; ifu_inst = 32'h0005_0733;
      #1;
      chk("lw10_issue", 32'(issue), 32'd1);
      tick;
      dec(1'b1, 5'd14, 5'd10, 5'd0, 1'b0);
      ifu_valid = 1'b0;
      #1;
      chk("use10_stall", 32'(hazard_stall), 32'd1);
      repeat (65600) tick;
      #1;
      chk("cnt_saturated", 32'(stall_cnt), 32'h0000_FFFF);
      chk("cnt_sat_stall", 32'(hazard_stall), 32'd1);
      rst_n = 1'b0;
      tick;
      #1;
      chk("midrst_id_valid", 32'(id_valid), 32'd0);
      chk("midrst_stall_cnt", 32'(stall_cnt), 32'd0);
      chk("midrst_id_inst", id_inst, 32'h13);
      chk("midrst_issue", 32'(issue), 32'd0);
      rst_n = 1'b1;
      ifu_valid = 1'b1; ifu_pc = 32'h60; ifu_inst = 32'h0005_0733;
      tick;
      ifu_valid = 1'b0;
      #1;
      chk("midrst_sb_cleared", 32'(hazard_stall), 32'd0);
      chk("midrst_issue_after", 32'(issue), 32'd1);
      chk("midrst_pc", id_pc, 32'h60);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/idu_issue_ctrl.md
Name: idu_issue_ctrl

Overview:
- Issue controller for the decode stage of the rvseed core.
- Holds one fetched instruction in a decode slot and exposes it to the instruction decoder.
- Tracks outstanding load destinations in a register scoreboard and stalls issue on load-use hazards.
- Issues to EXU with a valid/ready handshake and flushes the slot on a branch or jump redirect.

Parameters:
- CPU_WIDTH, 32, width of pc and instruction.
- REG_ADDR_WIDTH, 5, register address width; scoreboard depth is 2**REG_ADDR_WIDTH.
- CNT_WIDTH, 16, width of the stall performance counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- enable  in  1  rvseed enable; low freezes all state.
- ifu_valid  in  1  IFU offers an instruction.
- ifu_pc  in  CPU_WIDTH  offered pc.
- ifu_inst  in  CPU_WIDTH  offered instruction.
- ifu_ready  out  1  slot accepts this cycle.
- id_valid  out  1  slot holds a live instruction.
- id_pc  out  CPU_WIDTH  slot pc.
- id_inst  out  CPU_WIDTH  slot instruction; drives the decoder.
- dec_reg_wen  in  1  decoder result for id_inst: register write.
- dec_reg_waddr  in  REG_ADDR_WIDTH  decoder result: rd.
- dec_reg1_raddr  in  REG_ADDR_WIDTH  decoder result: rs1.
- dec_reg2_raddr  in  REG_ADDR_WIDTH  decoder result: rs2.
- dec_mem_ren  in  1  decoder result: instruction is a load.
- exu_ready  in  1  EXU can take an instruction.
- issue  out  1  single-cycle issue pulse to EXU.
- hazard_stall  out  1  slot valid but blocked by the scoreboard.
- exu_branch_en  in  1  taken branch redirect.
- exu_jump_en  in  1  jump redirect.
- wb_valid  in  1  load writeback completes.
- wb_addr  in  REG_ADDR_WIDTH  destination of the completing load.
- stall_cnt  out  CNT_WIDTH  count of hazard-stall cycles.

Behaviour:
- Reset (rst_n low at a clk edge):
  - id_valid=0, id_pc=0, id_inst=0x00000013 (NOP).
  - Scoreboard all 0, stall_cnt=0.
  - ifu_ready, issue and hazard_stall evaluate to 0 during reset.
  - Reset mid-operation discards the slot and all pending bits immediately.
- Redirect: flush = exu_branch_en | exu_jump_en.
- Hazard (combinational):
  - hazard = id_valid & ((sb[dec_reg1_raddr] & dec_reg1_raddr!=0) | (sb[dec_reg2_raddr] & dec_reg2_raddr!=0)).
  - hazard_stall = hazard & enable.
- Issue: issue = enable & id_valid & exu_ready & ~hazard & ~flush. It is combinational; EXU samples the decoder outputs in the same cycle.
- Accept: ifu_ready = enable & ~flush & (~id_valid | issue).
- Slot update at each clk edge with enable=1:
  - flush: id_valid<=0 and the slot contents are held. A flush takes priority over issue and accept, and an offered instruction is dropped.
  - Otherwise ifu_valid & ifu_ready: load ifu_pc and ifu_inst, id_valid<=1. This gives back-to-back issue with zero bubbles.
  - Otherwise issue: id_valid<=0.
  - Otherwise hold.
- Slot states:
  - EMPTY -> FULL on accept.
  - FULL -> FULL on issue with simultaneous accept.
  - FULL -> EMPTY on issue without accept, or on flush.
  - FULL -> FULL held while hazard or ~exu_ready.
  - Decode-to-issue latency is 1 cycle from accept when there is no hazard.
- Scoreboard (one bit per register):
  - Set sb[dec_reg_waddr] when issue & dec_mem_ren & dec_reg_wen & dec_reg_waddr!=0.
  - Clear sb[wb_addr] when wb_valid & wb_addr!=0.
  - Set and clear of the same address in the same cycle: set wins.
  - Register 0 is never set.
  - A flush does not clear the scoreboard, because in-flight loads still write back.
- Non-load writes are not scoreboarded; EXU forwarding covers them.
- stall_cnt increments on each cycle with hazard_stall=1 and saturates at all-ones without wrapping.
- enable=0:
  - issue=0, ifu_ready=0.
  - Slot and counter hold.
  - Scoreboard clears from wb_valid are still applied, so no writeback is lost.

Test Plan:
- Reset then ifu_valid=1, pc=0x0, inst=ADDI, exu_ready=1 -> ifu_ready=1 at cycle 0; id_valid=1 and issue=1 at cycle 1; a stream of 4 instructions issues on 4 consecutive cycles.
- Issue LW x5, then next inst ADD x6,x5,x1 -> issue=1 for the LW; ADD held with hazard_stall=1 and ifu_ready=0 until wb_valid=1, wb_addr=5; ADD issues the cycle after; stall_cnt equals the stall cycle count.
- LW x0 followed by a consumer of x0 -> no scoreboard set, no stall.
- Slot full, exu_jump_en=1 with ifu_valid=1 -> issue=0, ifu_ready=0; next cycle id_valid=0 and the offered instruction is not loaded; pending sb bits are unchanged.
- Same-cycle issue of LW x7 and wb_valid for x7 -> sb[7]=1 afterwards, and the next consumer of x7 stalls.
- enable=0 for 3 cycles with a full slot and a wb_valid clear -> no issue, slot and stall_cnt frozen, sb bit cleared; rst_n=0 mid-stall -> id_valid=0, sb=0, stall_cnt=0 on the next edge.
